// File: rtl/conv_mem_host_if.sv
// CONV-side memory bus: handshake, image read port, layer-memory read/write port.
interface conv_mem_host_if #(
  parameter int AW = 12,
  parameter int DW = 20
);
  logic          ready;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;

  // CONV side
  modport master (
    input  ready, idata, cdata_rd,
    output busy, iaddr, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );

  // memory host side
  modport slave (
    output ready, idata, cdata_rd,
    input  busy, iaddr, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );
endinterface

// File: rtl/conv_mem_host.sv
// Memory host for CONV: image ROM, five layer banks, ready/busy sequencing,
// host load/dump port, timeout and bank-select error reporting.
module conv_mem_host #(
  parameter int AW      = 12,
  parameter int DW      = 20,
  parameter int TIMEOUT = 1000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  conv_mem_host_if.slave bus,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic [2:0]    dump_sel,
  output logic [DW-1:0] dump_rdata,
  output logic          done,
  output logic          timeout,
  output logic          sel_err,
  output logic [AW:0]   wr_count
);
  localparam int NB = 5;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] WR_MAX = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, REQ, RUN, DONE} state_t;

  state_t st, nxt;
  logic [TW-1:0] cnt;
  logic          to_hit;
  logic          csel_ok, wr_ok;
  logic [NB-1:0][DW-1:0] rd_w, dp_w;
  logic [DW-1:0] rd_sel, dp_sel;
  logic [DW-1:0] img [2**AW];

  assign csel_ok = (bus.csel != 3'd0) && (bus.csel <= 3'd5);
  assign wr_ok   = bus.cwr && csel_ok;

  // Layer banks: one write port shared with CONV, CONV read port, dump read port
  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [DW-1:0] mem [2**AW];
    // bank write, only when this bank is selected
    always_ff @(posedge clk)
      if (bus.cwr && bus.csel == 3'(b + 1)) mem[bus.caddr_wr] <= bus.cdata_wr;
    assign rd_w[b] = mem[bus.caddr_rd];
    assign dp_w[b] = mem[host_addr];
  end

  // bank select muxes; invalid encodings fall through to zero
  always_comb begin
    rd_sel = '0;
    dp_sel = '0;
    for (int b = 0; b < NB; b++) begin
      if (bus.csel == 3'(b + 1)) rd_sel = rd_w[b];
      if (dump_sel == 3'(b + 1)) dp_sel = dp_w[b];
    end
  end

  // image load from host, locked out while CONV is running
  always_ff @(posedge clk)
    if (host_we && st != RUN) img[host_addr] <= host_wdata;

  // registered read ports; layer read holds when crd is low
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.idata  <= '0;
      bus.cdata_rd <= '0;
      dump_rdata <= '0;
    end else begin
      bus.idata  <= img[bus.iaddr];
      dump_rdata <= dp_sel;
      if (bus.crd) bus.cdata_rd <= rd_sel;
    end

  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= IDLE;
    else       st <= nxt;

  // next state; timeout fires as the counter steps onto TIMEOUT-1
  always_comb begin
    nxt    = st;
    to_hit = 1'b0;
    unique case (st)
      IDLE: if (start) nxt = REQ;
      REQ: begin
        if (cnt == TW'(TIMEOUT - 2)) begin to_hit = 1'b1; nxt = IDLE; end
        else if (bus.busy)           nxt = RUN;
      end
      RUN: begin
        if (cnt == TW'(TIMEOUT - 2)) begin to_hit = 1'b1; nxt = IDLE; end
        else if (!bus.busy)          nxt = DONE;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign bus.ready = (st == REQ);
  assign done      = (st == DONE);

  // run bookkeeping: timeout counter, sticky flags, saturating write count
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt      <= '0;
      timeout  <= 1'b0;
      sel_err  <= 1'b0;
      wr_count <= '0;
    end else begin
      if (st == IDLE && start)
        cnt <= '0;
      else if ((st == REQ || st == RUN) && cnt != TW'(TIMEOUT - 1))
        cnt <= cnt + 1'b1;
      if (to_hit) timeout <= 1'b1;
      if ((bus.crd || bus.cwr) && !csel_ok) sel_err <= 1'b1;
      if (st == IDLE && start)
        wr_count <= '0;
      else if (wr_ok && wr_count != WR_MAX)
        wr_count <= wr_count + 1'b1;
    end
endmodule

// File: tb/tb_conv_mem_host.sv
// Directed bench for conv_mem_host: handshake timing, image/bank paths,
// collisions, error flags, timeout (separate short-TIMEOUT instance), reset.
module tb_conv_mem_host;
  localparam int AW = 12;
  localparam int DW = 20;

  logic clk = 1'b0;
  logic rst;
  logic start, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [2:0] dump_sel;
  logic [DW-1:0] dump_rdata, dump_rdata_t;
  logic done, timeout, sel_err, done_t, timeout_t, sel_err_t;
  logic [AW:0] wr_count, wr_count_t;
  int n_run = 0;
  int n_fail = 0;

  conv_mem_host_if #(.AW(AW), .DW(DW)) bus ();
  conv_mem_host_if #(.AW(AW), .DW(DW)) bus_t ();

  conv_mem_host #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(rst), .start(start), .bus(bus),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .dump_sel(dump_sel), .dump_rdata(dump_rdata), .done(done),
    .timeout(timeout), .sel_err(sel_err), .wr_count(wr_count));

  conv_mem_host #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut_t (
    .clk(clk), .reset(rst), .start(start), .bus(bus_t),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .dump_sel(dump_sel), .dump_rdata(dump_rdata_t), .done(done_t),
    .timeout(timeout_t), .sel_err(sel_err_t), .wr_count(wr_count_t));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    start = 0; host_we = 0; host_addr = '0; host_wdata = '0; dump_sel = 3'd0;
    bus.busy = 0; bus.iaddr = '0; bus.crd = 0; bus.caddr_rd = '0;
    bus.cwr = 0; bus.caddr_wr = '0; bus.cdata_wr = '0; bus.csel = 3'd0;
    bus_t.busy = 0; bus_t.iaddr = '0; bus_t.crd = 0; bus_t.caddr_rd = '0;
    bus_t.cwr = 0; bus_t.caddr_wr = '0; bus_t.cdata_wr = '0; bus_t.csel = 3'd0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_run++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b exp 0", bus.ready); end
    n_run++; if (bus.idata !== '0) begin n_fail++; $display("FAIL rst_idata got %h exp 0", bus.idata); end
    n_run++; if (bus.cdata_rd !== '0) begin n_fail++; $display("FAIL rst_cdata got %h exp 0", bus.cdata_rd); end
    n_run++; if (dump_rdata !== '0) begin n_fail++; $display("FAIL rst_dump got %h exp 0", dump_rdata); end
    n_run++; if ({done, timeout, sel_err} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b exp 000", {done, timeout, sel_err}); end
    n_run++; if (wr_count !== '0) begin n_fail++; $display("FAIL rst_wrcnt got %0d exp 0", wr_count); end
    #1 rst = 0;
    tick();
  endtask

  // start in cycle 0, busy high cycles 3..50, second start in cycle 53
  task automatic test_handshake();
    logic er, ed;
    do_reset();
    for (int c = 0; c <= 54; c++) begin
      start = (c == 0 || c == 53);
      bus.busy = (c >= 3 && c <= 50);
      @(negedge clk);
      er = (c >= 1 && c <= 3) || (c == 54);
      ed = (c == 52);
      n_run++; if (bus.ready !== er) begin n_fail++; $display("FAIL hs_ready c=%0d got %b exp %b", c, bus.ready, er); end
      n_run++; if (done !== ed) begin n_fail++; $display("FAIL hs_done c=%0d got %b exp %b", c, done, ed); end
      tick();
    end
    start = 0;
  endtask

  // TIMEOUT=16 instance, busy never rises
  task automatic test_timeout();
    logic et, er;
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      start = (c == 0);
      @(negedge clk);
      et = (c >= 16);
      er = (c >= 1 && c <= 15);
      n_run++; if (timeout_t !== et) begin n_fail++; $display("FAIL to_flag c=%0d got %b exp %b", c, timeout_t, et); end
      n_run++; if (bus_t.ready !== er) begin n_fail++; $display("FAIL to_ready c=%0d got %b exp %b", c, bus_t.ready, er); end
      n_run++; if (done_t !== 1'b0) begin n_fail++; $display("FAIL to_done c=%0d got %b exp 0", c, done_t); end
      tick();
    end
    start = 0;
    // idle again: a new start must produce ready
    start = 1; tick(); start = 0;
    @(negedge clk);
    n_run++; if (bus_t.ready !== 1'b1) begin n_fail++; $display("FAIL to_idle got %b exp 1", bus_t.ready); end
    tick();
  endtask

  task automatic test_image();
    do_reset();
    host_we = 1; host_addr = 12'h000; host_wdata = 20'h12345; tick();
    host_addr = 12'hFFF; host_wdata = 20'hABCDE; tick();
    host_we = 0; bus.iaddr = 12'hFFF; tick();
    bus.iaddr = 12'h000;
    @(negedge clk);
    n_run++; if (bus.idata !== 20'hABCDE) begin n_fail++; $display("FAIL img_fff got %h exp abcde", bus.idata); end
    tick();
    @(negedge clk);
    n_run++; if (bus.idata !== 20'h12345) begin n_fail++; $display("FAIL img_000 got %h exp 12345", bus.idata); end
    // host write to the address being read: old data first
    host_we = 1; host_addr = 12'h000; host_wdata = 20'h55555; tick();
    host_we = 0;
    @(negedge clk);
    n_run++; if (bus.idata !== 20'h12345) begin n_fail++; $display("FAIL img_rbw got %h exp 12345", bus.idata); end
    tick();
    @(negedge clk);
    n_run++; if (bus.idata !== 20'h55555) begin n_fail++; $display("FAIL img_new got %h exp 55555", bus.idata); end
    // host writes are locked out in RUN
    start = 1; tick(); start = 0; bus.busy = 1; tick(); tick();
    host_we = 1; host_wdata = 20'h77777; tick();
    host_we = 0; tick();
    @(negedge clk);
    n_run++; if (bus.idata !== 20'h55555) begin n_fail++; $display("FAIL img_run_lock got %h exp 55555", bus.idata); end
    tick();
  endtask

  task automatic test_banks();
    do_reset();
    bus.cwr = 1; bus.csel = 3'b101; bus.caddr_wr = 12'd5; bus.cdata_wr = 20'h0; tick();
    bus.cwr = 0; start = 1; tick();
    start = 0;
    bus.cwr = 1; bus.csel = 3'b001; bus.cdata_wr = 20'h00011; tick();
    bus.csel = 3'b010; bus.cdata_wr = 20'h00022; tick();
    bus.cwr = 0; bus.crd = 1; bus.caddr_rd = 12'd5; bus.csel = 3'b001; tick();
    bus.csel = 3'b010;
    @(negedge clk);
    n_run++; if (bus.cdata_rd !== 20'h00011) begin n_fail++; $display("FAIL bank_l0m0 got %h exp 00011", bus.cdata_rd); end
    tick();
    bus.csel = 3'b101;
    @(negedge clk);
    n_run++; if (bus.cdata_rd !== 20'h00022) begin n_fail++; $display("FAIL bank_l0m1 got %h exp 00022", bus.cdata_rd); end
    tick();
    bus.crd = 0; bus.csel = 3'b001;
    @(negedge clk);
    n_run++; if (bus.cdata_rd !== 20'h0) begin n_fail++; $display("FAIL bank_l2 got %h exp 00000", bus.cdata_rd); end
    n_run++; if (wr_count !== 13'd2) begin n_fail++; $display("FAIL bank_wrcnt got %0d exp 2", wr_count); end
    tick();
    @(negedge clk);
    n_run++; if (bus.cdata_rd !== 20'h0) begin n_fail++; $display("FAIL bank_hold got %h exp 00000", bus.cdata_rd); end
    dump_sel = 3'b001; host_addr = 12'd5; tick();
    dump_sel = 3'b110;
    @(negedge clk);
    n_run++; if (dump_rdata !== 20'h00011) begin n_fail++; $display("FAIL dump_l0m0 got %h exp 00011", dump_rdata); end
    tick();
    @(negedge clk);
    n_run++; if (dump_rdata !== 20'h0) begin n_fail++; $display("FAIL dump_inv got %h exp 00000", dump_rdata); end
  endtask

  task automatic test_collision();
    bus.cwr = 1; bus.csel = 3'b011; bus.caddr_wr = 12'd7; bus.cdata_wr = 20'h00AAA; tick();
    bus.crd = 1; bus.caddr_rd = 12'd7; bus.cdata_wr = 20'h00BBB; tick();
    bus.cwr = 0;
    @(negedge clk);
    n_run++; if (bus.cdata_rd !== 20'h00AAA) begin n_fail++; $display("FAIL coll_old got %h exp 00aaa", bus.cdata_rd); end
    tick();
    bus.crd = 0;
    @(negedge clk);
    n_run++; if (bus.cdata_rd !== 20'h00BBB) begin n_fail++; $display("FAIL coll_new got %h exp 00bbb", bus.cdata_rd); end
  endtask

  task automatic test_errors();
    n_run++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL err_pre got %b exp 0", sel_err); end
    bus.cwr = 1; bus.csel = 3'b111; bus.caddr_wr = 12'd5; bus.cdata_wr = 20'hFFFFF; tick();
    bus.cwr = 0; dump_sel = 3'b001; host_addr = 12'd5; tick();
    dump_sel = 3'b010;
    @(negedge clk);
    n_run++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL err_flag got %b exp 1", sel_err); end
    n_run++; if (wr_count !== 13'd4) begin n_fail++; $display("FAIL err_wrcnt got %0d exp 4", wr_count); end
    n_run++; if (dump_rdata !== 20'h00011) begin n_fail++; $display("FAIL err_l0m0 got %h exp 00011", dump_rdata); end
    tick();
    dump_sel = 3'b011; host_addr = 12'd7;
    @(negedge clk);
    n_run++; if (dump_rdata !== 20'h00022) begin n_fail++; $display("FAIL err_l0m1 got %h exp 00022", dump_rdata); end
    tick();
    bus.crd = 1; bus.csel = 3'b000;
    @(negedge clk);
    n_run++; if (dump_rdata !== 20'h00BBB) begin n_fail++; $display("FAIL err_l1m0 got %h exp 00bbb", dump_rdata); end
    tick();
    bus.crd = 0;
    @(negedge clk);
    n_run++; if (bus.cdata_rd !== 20'h0) begin n_fail++; $display("FAIL err_rd_inv got %h exp 00000", bus.cdata_rd); end
    n_run++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", sel_err); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    bus.csel = 3'b001;
    start = 1; tick();
    start = 0; bus.busy = 1; tick(); tick();
    @(negedge clk);
    #2 rst = 1;
    #1;
    n_run++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL rmr_ready got %b exp 0", bus.ready); end
    n_run++; if ({done, sel_err, timeout} !== 3'b000) begin n_fail++; $display("FAIL rmr_flags got %b exp 000", {done, sel_err, timeout}); end
    n_run++; if (wr_count !== '0) begin n_fail++; $display("FAIL rmr_wrcnt got %0d exp 0", wr_count); end
    tick();
    rst = 0; bus.busy = 0; dump_sel = 3'b001; host_addr = 12'd5; tick();
    @(negedge clk);
    n_run++; if (dump_rdata !== 20'h00011) begin n_fail++; $display("FAIL rmr_dump got %h exp 00011", dump_rdata); end
    n_run++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL rmr_idle got %b exp 0", bus.ready); end
    tick();
  endtask

  task automatic test_wr_sat();
    do_reset();
    bus.cwr = 1; bus.csel = 3'b100;
    for (int i = 0; i < 10; i++) begin bus.caddr_wr = AW'(i); tick(); end
    @(negedge clk);
    n_run++; if (wr_count !== 13'd10) begin n_fail++; $display("FAIL sat_10 got %0d exp 10", wr_count); end
    tick();
    for (int i = 11; i < 4100; i++) begin bus.caddr_wr = AW'(i); tick(); end
    bus.cwr = 0;
    @(negedge clk);
    n_run++; if (wr_count !== 13'd4096) begin n_fail++; $display("FAIL sat_max got %0d exp 4096", wr_count); end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_timeout();
    test_image();
    test_banks();
    test_collision();
    test_errors();
    test_reset_mid_run();
    test_wr_sat();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_mem_host.md
Name: conv_mem_host

Overview:
- Responder/host end of the CONV accelerator's memory interface: image ROM on iaddr/idata, layer-memory bank array on cwr/crd/caddr_*/cdata_*/csel.
- Sequences the ready/busy handshake and reports completion.
- Used as the synthesizable memory subsystem beside CONV on FPGA/emulation, and as the bench-side model.
- A host load/dump port fills the image and reads results back.

Parameters:
- AW, 12, address width; depth = 2**AW words per memory.
- DW, 20, data word width.
- TIMEOUT, 1000000, cycles allowed from ready to busy fall before timeout is flagged.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  host pulse; begins a run when the FSM is in IDLE.
- ready  out  1  to CONV.
- busy  in  1  from CONV.
- iaddr  in  AW  image read address from CONV.
- idata  out  DW  image data to CONV.
- crd  in  1  layer-memory read enable.
- caddr_rd  in  AW  layer-memory read address.
- cdata_rd  out  DW  layer-memory read data.
- cwr  in  1  layer-memory write enable.
- caddr_wr  in  AW  layer-memory write address.
- cdata_wr  in  DW  layer-memory write data.
- csel  in  3  bank select for both read and write.
- host_we  in  1  image write strobe.
- host_addr  in  AW  image or dump address.
- host_wdata  in  DW  image write data.
- dump_sel  in  3  bank to dump; same encoding as csel.
- dump_rdata  out  DW  dump data.
- done  out  1  one-cycle completion pulse.
- timeout  out  1  sticky timeout flag.
- sel_err  out  1  sticky invalid-csel flag.
- wr_count  out  AW+1  writes accepted in the current run.

Behaviour:
- Bank encoding (csel and dump_sel):
  - 3'b001 L0_MEM0, 3'b010 L0_MEM1, 3'b011 L1_MEM0, 3'b100 L1_MEM1, 3'b101 L2_MEM.
  - 3'b000, 3'b110, 3'b111 are invalid.
- Reset values: ready=0, idata=0, cdata_rd=0, dump_rdata=0, done=0, timeout=0, sel_err=0, wr_count=0, FSM=IDLE. Memory contents are not reset.
- Image read: idata = IMG[iaddr] registered every cycle. Latency 1, unconditional, no enable.
- Layer read:
  - When crd=1 at an edge, cdata_rd = BANK[csel][caddr_rd] on the next cycle.
  - When crd=0, cdata_rd holds its value.
  - Invalid csel returns 0.
- Layer write: when cwr=1 at an edge and csel is valid, BANK[csel][caddr_wr] <= cdata_wr and wr_count increments.
- Invalid csel with crd=1 or cwr=1: the write is dropped and sel_err sets; it is cleared only by reset.
- Simultaneous crd and cwr on the same bank and same address: the read returns the old data (read-before-write).
- Different banks are independent.
- Host writes: host_we writes IMG[host_addr] <= host_wdata.
  - If iaddr==host_addr in the same cycle, idata shows the old value.
  - Host writes are ignored while the FSM is in RUN.
- Dump read: dump_rdata = BANK[dump_sel][host_addr], 1-cycle latency; invalid dump_sel returns 0. This read is non-intrusive to CONV reads.
- FSM states:
  - IDLE: ready=0. start=1 → REQ, with wr_count cleared and the timeout counter cleared.
  - REQ: ready=1. busy=1 sampled → RUN, with ready dropping to 0 in the same transition (ready is high until the cycle after busy is first seen).
  - RUN: ready=0. busy=0 sampled → DONE.
  - DONE: done=1 for one cycle → IDLE.
- start is ignored outside IDLE.
- Timeout counter: counts in REQ and RUN. On reaching TIMEOUT-1, timeout sets and FSM → IDLE; the counter saturates.
- Reset mid-run: immediate return to IDLE with ready=0. Memory retains its contents.
- wr_count saturates at 2**AW; no wrap.

Test Plan:
- Handshake:
  - Stimulus: start pulse at cycle 0; busy rises at cycle 3; busy falls at cycle 50.
  - Required: ready=1 during cycles 1–3 and 0 from cycle 4; done=1 exactly at cycle 52; FSM back in IDLE at cycle 53.
- Image path:
  - Stimulus: host loads IMG[0x000]=0x12345, IMG[0xFFF]=0xABCDE; CONV drives iaddr=0xFFF then 0x000.
  - Required: idata=0xABCDE then 0x12345, each one cycle after its address.
- Bank isolation:
  - Stimulus: cwr with csel=3'b001, addr 5, data 0x00011; then cwr with csel=3'b010, addr 5, data 0x00022; then crd at addr 5 with csel 001, then 010, then 101.
  - Required: cdata_rd=0x00011, 0x00022, then 0x00000 (if L2_MEM is unwritten, pre-cleared via writes); wr_count=2.
- Read/write collision:
  - Stimulus: BANK3[7]=0x00AAA; in one cycle, crd=1 and cwr=1 with csel=3'b011, addr 7, data 0x00BBB.
  - Required: cdata_rd=0x00AAA; the next read returns 0x00BBB.
- Error paths:
  - Stimulus: cwr with csel=3'b111.
  - Required: no bank changes, sel_err=1, wr_count unchanged.
  - Stimulus: TIMEOUT=16 with busy held 0 after start.
  - Required: timeout=1 at cycle 16, FSM in IDLE, no done pulse.
- Reset mid-run:
  - Stimulus: assert reset while in RUN.
  - Required: ready=0, done=0, flags cleared in the same cycle; a subsequent dump returns the pre-reset bank data.
